// File: rtl/minisrc_pkg.sv
// Shared Mini SRC definitions: memory-unit FSM states and default datapath widths.
package minisrc_pkg;

  localparam int MINISRC_DATA_WIDTH = 32;
  localparam int MINISRC_ADDR_WIDTH = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } mdr_state_e;

endpackage

// File: rtl/mux_2_to_1.sv
// Generic two-input word select; y = d1 when sel is high, d0 otherwise.
module mux_2_to_1 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/mdr_memory_unit.sv
// Mini SRC memory data register plus a single-outstanding RAM read/write controller.
// Reads land in the MDR on the ack edge; a missing ack aborts after TIMEOUT cycles.
module mdr_memory_unit
  import minisrc_pkg::*;
#(
  parameter int DATA_WIDTH = MINISRC_DATA_WIDTH,
  parameter int ADDR_WIDTH = MINISRC_ADDR_WIDTH,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] bus_in,
  input  logic                  mdr_in,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] mar_addr,
  output logic [DATA_WIDTH-1:0] mdr_out,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err
);

  localparam int             CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  TERM = CW'(TIMEOUT - 1);

  mdr_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] mdr_q, mdr_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  done_q, done_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  mux_sel;
  logic [DATA_WIDTH-1:0] mux_y;

  mux_2_to_1 #(.WIDTH(DATA_WIDTH)) u_mdr_mux (
    .d0  (bus_in),
    .d1  (mem_rdata),
    .sel (mux_sel),
    .y   (mux_y)
  );

  always_comb begin
    state_d       = state_q;
    mdr_d         = mdr_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    done_d        = 1'b0;
    timeout_err_d = timeout_err_q;
    cnt_d         = cnt_q;
    mux_sel       = 1'b0;

    case (state_q)
      IDLE: begin
        if (read && mdr_in) begin
          mem_addr_d    = mar_addr;
          mem_req_d     = 1'b1;
          mem_we_d      = 1'b0;
          timeout_err_d = 1'b0;
          cnt_d         = '0;
          state_d       = RD_WAIT;
        end else if (write) begin
          mem_addr_d    = mar_addr;
          mem_wdata_d   = mdr_q;
          mem_req_d     = 1'b1;
          mem_we_d      = 1'b1;
          timeout_err_d = 1'b0;
          cnt_d         = '0;
          state_d       = WR_WAIT;
        end else if (mdr_in && !read) begin
          mdr_d = mux_y;
        end
      end
      RD_WAIT, WR_WAIT: begin
        // An ack on the terminal-count cycle still completes normally.
        if (mem_ack) begin
          if (state_q == RD_WAIT) begin
            mux_sel = 1'b1;
            mdr_d   = mux_y;
          end
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == TERM) begin
            mem_req_d     = 1'b0;
            timeout_err_d = 1'b1;
            done_d        = 1'b1;
            state_d       = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q       <= IDLE;
      mdr_q         <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      mdr_q         <= mdr_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign mdr_out     = mdr_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mdr_memory_unit.sv
// Directed bench for mdr_memory_unit with TIMEOUT=4; expected values are hand-computed.
module tb_mdr_memory_unit;

  localparam int DW = 32;
  localparam int AW = 9;

  logic          clock = 1'b0;
  logic          clear = 1'b0;
  logic [DW-1:0] bus_in = '0;
  logic          mdr_in = 1'b0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [AW-1:0] mar_addr = '0;
  logic [DW-1:0] mdr_out;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          busy;
  logic          done;
  logic          timeout_err;

  int errors = 0;
  int checks = 0;

  mdr_memory_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(4)) dut (
    .clock       (clock),
    .clear       (clear),
    .bus_in      (bus_in),
    .mdr_in      (mdr_in),
    .read        (read),
    .write       (write),
    .mar_addr    (mar_addr),
    .mdr_out     (mdr_out),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Asynchronous clear between edges.
    #3 clear = 1'b1;
    #1;
    chk("rst_mdr_out", mdr_out, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {23'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_terr", {31'd0, timeout_err}, 32'd0);
    step();
    step();
    clear = 1'b0;

    // Bus load, with no same-cycle bypass.
    bus_in = 32'd15;
    mdr_in = 1'b1;
    #1;
    chk("load_no_bypass", mdr_out, 32'd0);
    step();
    mdr_in = 1'b0;
    chk("load_mdr", mdr_out, 32'd15);
    chk("load_no_req", {31'd0, mem_req}, 32'd0);
    chk("load_not_busy", {31'd0, busy}, 32'd0);

    // read with mdr_in low does nothing.
    read = 1'b1;
    bus_in = 32'd1;
    step();
    read = 1'b0;
    chk("read_only_idle", {31'd0, busy}, 32'd0);
    chk("read_only_mdr", mdr_out, 32'd15);

    // Read, ack three cycles after the command edge.
    mar_addr = 9'h012;
    bus_in = 32'h55;
    read = 1'b1;
    mdr_in = 1'b1;
    step();
    read = 1'b0;
    mdr_in = 1'b0;
    mar_addr = 9'h000;
    chk("rd_req", {31'd0, mem_req}, 32'd1);
    chk("rd_we", {31'd0, mem_we}, 32'd0);
    chk("rd_addr", {23'd0, mem_addr}, 32'h012);
    chk("rd_busy1", {31'd0, busy}, 32'd1);
    chk("rd_mdr_hold", mdr_out, 32'd15);
    bus_in = 32'h77;
    mdr_in = 1'b1;
    step();
    mdr_in = 1'b0;
    chk("rd_busy2", {31'd0, busy}, 32'd1);
    chk("busy_ignores_mdr_in", mdr_out, 32'd15);
    step();
    chk("rd_busy3", {31'd0, busy}, 32'd1);
    chk("rd_addr_stable", {23'd0, mem_addr}, 32'h012);
    mem_ack = 1'b1;
    mem_rdata = 32'd240;
    step();
    mem_ack = 1'b0;
    chk("rd_data", mdr_out, 32'd240);
    chk("rd_done", {31'd0, done}, 32'd1);
    chk("rd_busy_low", {31'd0, busy}, 32'd0);
    chk("rd_req_low", {31'd0, mem_req}, 32'd0);
    chk("rd_terr", {31'd0, timeout_err}, 32'd0);
    step();
    chk("rd_done_pulse", {31'd0, done}, 32'd0);

    // Write of the current MDR, ack after one cycle.
    bus_in = 32'hDEADBEEF;
    mdr_in = 1'b1;
    step();
    mdr_in = 1'b0;
    write = 1'b1;
    mar_addr = 9'h1FF;
    step();
    write = 1'b0;
    bus_in = 32'h0;
    chk("wr_req", {31'd0, mem_req}, 32'd1);
    chk("wr_we", {31'd0, mem_we}, 32'd1);
    chk("wr_addr", {23'd0, mem_addr}, 32'h1FF);
    chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
    mem_ack = 1'b1;
    mem_rdata = 32'h12345678;
    step();
    mem_ack = 1'b0;
    chk("wr_done", {31'd0, done}, 32'd1);
    chk("wr_mdr_kept", mdr_out, 32'hDEADBEEF);
    chk("wr_busy_low", {31'd0, busy}, 32'd0);

    // Read with no ack: abort after edge N+4.
    mar_addr = 9'h0A5;
    read = 1'b1;
    mdr_in = 1'b1;
    step();
    read = 1'b0;
    mdr_in = 1'b0;
    step();
    step();
    step();
    chk("to_busy_n3", {31'd0, busy}, 32'd1);
    chk("to_done_n3", {31'd0, done}, 32'd0);
    chk("to_terr_n3", {31'd0, timeout_err}, 32'd0);
    step();
    chk("to_done", {31'd0, done}, 32'd1);
    chk("to_terr", {31'd0, timeout_err}, 32'd1);
    chk("to_req_low", {31'd0, mem_req}, 32'd0);
    chk("to_busy_low", {31'd0, busy}, 32'd0);
    chk("to_mdr_kept", mdr_out, 32'hDEADBEEF);
    step();
    chk("to_terr_sticky", {31'd0, timeout_err}, 32'd1);

    // Next read clears the flag; ack on the terminal-count cycle wins.
    read = 1'b1;
    mdr_in = 1'b1;
    step();
    read = 1'b0;
    mdr_in = 1'b0;
    chk("to_terr_cleared", {31'd0, timeout_err}, 32'd0);
    step();
    step();
    step();
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFE0001;
    step();
    mem_ack = 1'b0;
    chk("term_ack_done", {31'd0, done}, 32'd1);
    chk("term_ack_terr", {31'd0, timeout_err}, 32'd0);
    chk("term_ack_data", mdr_out, 32'hCAFE0001);

    // New command accepted while done is high.
    write = 1'b1;
    mar_addr = 9'h033;
    step();
    write = 1'b0;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("b2b_we", {31'd0, mem_we}, 32'd1);
    chk("b2b_wdata", mem_wdata, 32'hCAFE0001);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("b2b_done", {31'd0, done}, 32'd1);

    // read+write+mdr_in together: the read is performed.
    read = 1'b1;
    write = 1'b1;
    mdr_in = 1'b1;
    mar_addr = 9'h044;
    bus_in = 32'h99;
    step();
    read = 1'b0;
    write = 1'b0;
    mdr_in = 1'b0;
    chk("cont_we", {31'd0, mem_we}, 32'd0);
    chk("cont_addr", {23'd0, mem_addr}, 32'h044);
    chk("cont_no_load", mdr_out, 32'hCAFE0001);

    // Clear while waiting, then a late ack.
    #2 clear = 1'b1;
    #1;
    chk("clr_req_async", {31'd0, mem_req}, 32'd0);
    chk("clr_mdr", mdr_out, 32'd0);
    step();
    clear = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hBAD;
    step();
    mem_ack = 1'b0;
    chk("late_ack_mdr", mdr_out, 32'd0);
    chk("late_ack_done", {31'd0, done}, 32'd0);
    chk("late_ack_busy", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
